// File: rtl/baud_gen_frac.sv
// Fractional-N oversampling baud tick generator.
// Emits os_tick plus derived mid-bit and end-of-bit ticks for UART engines.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 65,
    parameter int DEFAULT_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              cfg_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick
);

    localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [SUB_W-1:0]  MID_IDX  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0]  LAST_IDX = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
    localparam logic [DIV_W:0]    CNT_ONE  = (DIV_W + 1)'(1);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DEFAULT_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(1);

    // Active divisor and phase state
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              c;
    logic [SUB_W-1:0]  sub_cnt;

    // Combinational helpers
    logic [DIV_W:0]    last_cnt;
    logic              wrap;
    logic [FRAC_W:0]   acc_sum;
    logic              restart;
    logic [DIV_W-1:0]  new_int;

    // Period end detection: this period lasts act_int clocks plus the
    // carry produced by the fractional accumulator at the previous wrap
    always_comb begin
        last_cnt = {1'b0, act_int} + {{DIV_W{1'b0}}, c} - CNT_ONE;
        wrap     = en && (cnt == last_cnt);
        acc_sum  = {1'b0, acc} + {1'b0, act_frac};
        restart  = cfg_load || resync;
        new_int  = (div_int == '0) ? MIN_INT : div_int;
    end

    // Divisor register: changes only on reset or cfg_load
    always_ff @(posedge clk) begin
        if (rst) begin
            act_int  <= RST_INT;
            act_frac <= RST_FRAC;
        end else if (cfg_load) begin
            act_int  <= new_int;
            act_frac <= div_frac;
        end
    end

    // Phase counters: restart on strobe, advance only when enabled
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt     <= '0;
            acc     <= '0;
            c       <= 1'b0;
            sub_cnt <= '0;
        end else if (en) begin
            if (wrap) begin
                cnt      <= '0;
                {c, acc} <= acc_sum;
                sub_cnt  <= sub_cnt + SUB_ONE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Registered ticks; mid/baud are qualified by the os wrap so they
    // can never appear without os_tick
    always_ff @(posedge clk) begin
        if (rst || restart || !en) begin
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else begin
            os_tick   <= wrap;
            mid_tick  <= wrap && (sub_cnt == MID_IDX);
            baud_tick <= wrap && (sub_cnt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: a closed-form tick-time model
// predicts every cycle's tick triple; a monitor compares on negedge.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic              clk;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              cfg_load;
    logic              resync;
    logic              os_tick;
    logic              mid_tick;
    logic              baud_tick;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int os_seen = 0;
    int baud_seen = 0;

    logic [2:0] exp_q[$];

    baud_gen_frac #(
        .DIV_W(DIV_W),
        .FRAC_W(FRAC_W),
        .OVERSAMPLE(OS),
        .DEFAULT_INT(65),
        .DEFAULT_FRAC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .div_int(div_int),
        .div_frac(div_frac),
        .cfg_load(cfg_load),
        .resync(resync),
        .os_tick(os_tick),
        .mid_tick(mid_tick),
        .baud_tick(baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the k-th os tick after a restart lands on enabled
    // cycle k*int + floor((k-1)*frac / 2^FRAC_W). Tick k is mid-bit when
    // k mod OS == OS/2 and end-of-bit when k mod OS == 0.
    int m_int;
    int m_frac;
    int m_e;
    int m_k;

    always @(posedge clk) begin
        int due;
        logic [2:0] exp_v;
        exp_v = 3'b000;
        cyc_no++;
        if (rst) begin
            m_int  = 65;
            m_frac = 2;
            m_e    = 0;
            m_k    = 0;
        end else if (cfg_load) begin
            m_int  = (div_int == 0) ? 1 : int'(div_int);
            m_frac = int'(div_frac);
            m_e    = 0;
            m_k    = 0;
        end else if (resync) begin
            m_e = 0;
            m_k = 0;
        end else if (en) begin
            m_e = m_e + 1;
            due = (m_k + 1) * m_int + ((m_k * m_frac) >> FRAC_W);
            if (m_e == due) begin
                m_k   = m_k + 1;
                exp_v = {1'b1, (m_k % OS) == OS / 2, (m_k % OS) == 0};
            end
        end
        exp_q.push_back(exp_v);
    end

    // Monitor: compare the DUT's tick triple against the queued prediction
    always @(negedge clk) begin
        logic [2:0] got;
        logic [2:0] exp_v;
        got = {os_tick, mid_tick, baud_tick};
        if (os_tick === 1'b1) os_seen++;
        if (baud_tick === 1'b1) baud_seen++;
        checks++;
        if (exp_q.size() == 0) begin
            if (got !== 3'b000) begin
                errors++;
                $display("FAIL ticks_noexp cyc=%0d got=%b exp=000", cyc_no, got);
            end
        end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
                errors++;
                $display("FAIL ticks cyc=%0d got(os,mid,baud)=%b exp=%b",
                         cyc_no, got, exp_v);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int i, input int f);
        div_int  = DIV_W'(i);
        div_frac = FRAC_W'(f);
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        step(1);
        resync = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_int  = '0;
        div_frac = '0;
        cfg_load = 1'b0;
        resync   = 1'b0;
        step(3);
        rst = 1'b0;
        en  = 1'b1;

        // Integer divisor 4: os every 4, mid at 32, baud at 64
        load(4, 0);
        step(200);

        // Resync 2 cycles before an expected os_tick
        load(4, 0);
        step(42);
        pulse_resync();
        step(80);

        // Enable low for 10 cycles mid-period
        step(2);
        en = 1'b0;
        step(10);
        en = 1'b1;
        step(100);

        // Fractional 4 + 8/16: periods 4,4,5,4,5...; baud at 71 then 72
        load(4, 8);
        step(300);

        // Zero divisor treated as 1: os every cycle
        load(0, 0);
        step(70);

        // Reset mid-bit returns to default 65 + 2/16
        load(4, 0);
        step(30);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(200);

        // cfg_load and resync together: new divisor wins
        resync = 1'b1;
        load(3, 5);
        resync = 1'b0;
        step(150);

        // Randomised run with small divisors, gated enable and strobes
        load(2, 3);
        for (int i = 0; i < 4000; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            resync = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 349) == 0) begin
                div_int  = DIV_W'($urandom_range(0, 6));
                div_frac = FRAC_W'($urandom_range(0, 15));
                cfg_load = 1'b1;
            end
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
            step(1);
            cfg_load = 1'b0;
            resync   = 1'b0;
            rst      = 1'b0;
        end
        en = 1'b1;
        step(20);

        @(negedge clk);
        #1;
        checks++;
        if (os_seen < 100 || baud_seen < 5) begin
            errors++;
            $display("FAIL activity os=%0d baud=%0d need>=100,>=5",
                     os_seen, baud_seen);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
